ex_burst_tx: RTL and testbench

Transmit-side companion to the exponent-accumulate unit.
- Buffers bf16 samples from upstream and, on command, emits them as one contiguous data-enable burst of programmable length.
- Enforces the mandatory idle gap after each burst.
- Waits for the accumulator's single-cycle fp32 result pulse, then holds that result under a valid/ready handshake.
- Sits between the softmax vector staging logic and the accumulator.

---
 rtl/ex_burst_tx.sv | 129 ++++++++++++
 tb/tb_ex_burst_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_burst_tx.sv
// ex_burst_tx: buffers bf16 samples and emits them as one data-enable burst, then
// waits for the accumulator's fp32 result and holds it under valid/ready.
module ex_burst_tx #(
  parameter int DEPTH        = 64,
  parameter int CNT_W        = $clog2(DEPTH+1),
  parameter int RESP_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             start_err,
  output logic             ex_data_en_o,
  output logic [15:0]      ex_data_o,
  input  logic             ex_data_en_i,
  input  logic [31:0]      ex_data_i,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ready,
  output logic             err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(RESP_TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;
  state_t           state_q, state_d;
  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d, rem_q, rem_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             en_o_q, en_o_d, res_valid_q, res_valid_d, start_err_q, start_err_d, err_to_q, err_to_d;
  logic [15:0]      data_o_q, data_o_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             push, pop;
  assign in_ready     = enable && (count_q < CNT_W'(DEPTH));
  assign push         = in_valid && in_ready;
  assign pop          = enable && (state_q == SEND);
  assign busy         = state_q != IDLE;
  assign start_err    = start_err_q;
  assign ex_data_en_o = en_o_q;
  assign ex_data_o    = data_o_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign err_timeout  = err_to_q;
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    en_o_d      = en_o_q;
    data_o_d    = data_o_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    start_err_d = start_err_q;
    err_to_d    = err_to_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    if (enable) begin
      start_err_d = 1'b0;
      err_to_d    = 1'b0;
      en_o_d      = 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (len != '0 && len <= count_q) begin
            state_d = SEND;
            rem_d   = len;
          end else start_err_d = 1'b1;
        end
        SEND: begin
          en_o_d   = 1'b1;
          data_o_d = mem[rd_ptr_q];
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = WAIT;
            tmo_d   = '0;
          end
        end
        // a strobe on the expiry cycle still wins over the timeout
        WAIT: if (ex_data_en_i) begin
          res_valid_d = 1'b1;
          res_data_d  = ex_data_i;
          state_d     = HOLD;
        end else if (tmo_q == TW'(RESP_TIMEOUT)) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else tmo_d = tmo_q + TW'(1);
        HOLD: if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      en_o_q      <= 1'b0;
      data_o_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      start_err_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q    <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q     <= count_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      en_o_q      <= en_o_d;
      data_o_q    <= data_o_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      start_err_q <= start_err_d;
      err_to_q    <= err_to_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_ex_burst_tx.sv
// tb_ex_burst_tx: directed stimulus with a scoreboard on the burst data and results,
// plus a small accumulator model that strobes the sum after each burst.
module tb_ex_burst_tx;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;
  localparam int RT    = 16;
  logic             clk = 1'b0;
  logic             rst_n, enable, in_valid, start, res_ready, ex_data_en_i;
  logic [15:0]      in_data;
  logic [CNT_W-1:0] len;
  logic [31:0]      ex_data_i;
  logic             in_ready, busy, start_err, ex_data_en_o, res_valid, err_timeout;
  logic [15:0]      ex_data_o;
  logic [31:0]      res_data;
  logic [15:0]      exp_data [$];
  logic [31:0]      exp_res [$];
  int               checks = 0, errors = 0, en_cnt = 0;
  logic             edge_en = 1'b0, prev_en = 1'b0, model_on = 1'b1;
  real              acc = 0.0;

  ex_burst_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .len(len), .busy(busy), .start_err(start_err),
    .ex_data_en_o(ex_data_en_o), .ex_data_o(ex_data_o), .ex_data_en_i(ex_data_en_i),
    .ex_data_i(ex_data_i), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic real bf2real(input logic [15:0] b);
    logic [10:0] e;
    if (b[14:0] == 15'd0) return 0.0;
    e = {3'b000, b[14:7]} + 11'd896;
    return $bitstoreal({b[15], e, b[6:0], 45'd0});
  endfunction

  function automatic logic [31:0] real2f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [15:0] int2bf16(input int k);
    int p = 0;
    for (int i = 0; i < 8; i++) if (k[i]) p = i;
    return {1'b0, 8'(127 + p), 7'((k << (7 - p)) & 127)};
  endfunction

  // Records whether the DUT actually advanced on the edge just taken.
  always @(posedge clk) edge_en = enable && rst_n;

  // Accumulator model: sums every consumed sample, strobes the sum once after en falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
      acc = 0.0;
      ex_data_en_i = 1'b0;
    end else if (edge_en) begin
      ex_data_en_i = 1'b0;
      if (ex_data_en_o) acc += bf2real(ex_data_o);
      else if (prev_en) begin
        if (model_on) begin
          ex_data_en_i = 1'b1;
          ex_data_i = real2f32(acc);
        end
        acc = 0.0;
      end
      prev_en = ex_data_en_o;
    end
  end

  // Monitors: burst data against the push order, results against the expected sums.
  always @(negedge clk) begin
    if (rst_n && edge_en && ex_data_en_o) begin
      en_cnt++;
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL burst_extra: got sample %h expected no sample", ex_data_o);
      end else chk("burst_data", {16'd0, ex_data_o}, {16'd0, exp_data.pop_front()});
    end
    if (rst_n && enable && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_extra: got result %h expected none", res_data);
      end else chk("res_data", res_data, exp_res.pop_front());
    end
  end

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_data.push_back(d);
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = CNT_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reject(input string nm, input int l);
    do_start(l);
    chk({nm, "_err"}, {31'd0, start_err}, 32'd1);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {31'd0, start_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, j;
    logic acc_ok;
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
    in_data = '0; len = '0; ex_data_en_i = 1'b0; ex_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {26'd0, busy, start_err, ex_data_en_o, res_valid, err_timeout, 1'b0}, 32'd0);
    chk("rst_data", {ex_data_o, 16'd0} | res_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    // 1: basic 3-sample burst, result held until res_ready
    push(16'h3F80); push(16'h4000); push(16'h4040);
    exp_res.push_back(32'h40C00000);
    c0 = en_cnt;
    do_start(3);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_valid && n < 40);
    chk("t1_latency", n, 5);
    chk("t1_en_cycles", en_cnt - c0, 3);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t1_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t1_hold_data", res_data, 32'h40C00000);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("t1_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    // 2: enable stall mid-burst
    push(16'h3F80); push(16'h4000); push(16'h4040); push(16'h4080);
    exp_res.push_back(32'h41200000);
    res_ready = 1'b1;
    c0 = en_cnt;
    do_start(4);
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_stall_en", {31'd0, ex_data_en_o}, 32'd1);
      chk("t2_stall_data", {16'd0, ex_data_o}, 32'h4000);
    end
    enable = 1'b1;
    wait_idle("t2_done");
    chk("t2_en_cycles", en_cnt - c0, 4);
    chk("t2_res_drained", exp_res.size(), 0);
    // 3: rejected starts, two samples left in the buffer
    push(16'h3F80); push(16'h4000);
    chk_reject("t3_len3", 3);
    chk_reject("t3_len0", 0);
    // 4: burst of the two leftovers with no strobe -> timeout
    model_on = 1'b0;
    c0 = en_cnt;
    do_start(2);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!err_timeout && n < 60);
    chk("t4_timeout_at", n, 2 + 1 + RT);
    chk("t4_en_cycles", en_cnt - c0, 2);
    chk("t4_idle", {30'd0, busy, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t4_pulse", {31'd0, err_timeout}, 32'd0);
    model_on = 1'b1;
    chk_reject("t4_empty", 1);
    ex_data_en_i = 1'b1;
    ex_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    ex_data_en_i = 1'b0;
    chk("t4_spurious", {30'd0, busy, res_valid}, 32'd0);
    // 5: full buffer, burst of DEPTH with concurrent pushes across the wrap
    for (int k = 1; k <= DEPTH; k++) push(int2bf16(k));
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    exp_res.push_back(32'h45020000);
    c0 = en_cnt;
    do_start(DEPTH);
    j = 0;
    for (int c = 0; c < 100 && j < 5; c++) begin
      in_valid = 1'b1;
      in_data = int2bf16(100 + j);
      acc_ok = in_ready;
      @(posedge clk); #1;
      if (acc_ok) begin
        exp_data.push_back(in_data);
        j++;
      end
    end
    in_valid = 1'b0;
    wait_idle("t5_done");
    chk("t5_pushed", j, 5);
    chk("t5_en_cycles", en_cnt - c0, DEPTH);
    chk_reject("t5_len6", 6);
    exp_res.push_back(32'h43FF0000);
    do_start(5);
    wait_idle("t5_tail");
    // 6: async reset during SEND
    push(16'h3F80); push(16'h4000);
    do_start(2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", {31'd0, ex_data_en_o}, 32'd0);
    chk("t6_rst_outs", {29'd0, busy, res_valid, err_timeout}, 32'd0);
    chk("t6_rst_data", {16'd0, ex_data_o}, 32'd0);
    exp_data.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(16'h3F80);
    chk_reject("t6_cleared", 2);
    exp_res.push_back(32'h3F800000);
    do_start(1);
    wait_idle("t6_done");
    repeat (3) @(posedge clk);
    #1;
    chk("end_data_drained", exp_data.size(), 0);
    chk("end_res_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
